// File: rtl/rv64b_ise_pkg.sv
// Shared opcodes, requester IDs and request struct for the rotate/pack ISE arbiter.
package rv64b_ise_pkg;

    localparam logic [1:0] OP_RORI  = 2'b00;
    localparam logic [1:0] OP_RORIW = 2'b01;
    localparam logic [1:0] OP_PACK  = 2'b10;
    localparam logic [1:0] OP_PACKU = 2'b11;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    typedef struct packed {
        logic rori;
        logic roriw;
        logic pack;
        logic packu;
    } op_sel_t;

    typedef struct packed {
        logic        vld;
        op_sel_t     sel;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [4:0]  imm;
        logic        id;
    } ise_req_t;

    function automatic op_sel_t dec_op(input logic [1:0] op);
        op_sel_t s;
        s = '0;
        case (op)
            OP_RORI:  s.rori  = 1'b1;
            OP_RORIW: s.roriw = 1'b1;
            OP_PACK:  s.pack  = 1'b1;
            default:  s.packu = 1'b1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/rv64b_ise.sv
// Combinational rotate/pack datapath; one-hot selects pick the result via an AND-OR mux.
module rv64b_ise (
    input  logic        sel_rori,
    input  logic        sel_roriw,
    input  logic        sel_pack,
    input  logic        sel_packu,
    input  logic [63:0] rs1,
    input  logic [63:0] rs2,
    input  logic [4:0]  imm,
    output logic [63:0] rd
);

    logic [63:0] rot64;
    logic [31:0] rot32;

    // A shift by the full width yields zero, so imm == 0 needs no special case.
    assign rot64 = (rs1 >> imm) | (rs1 << (7'd64 - {2'b00, imm}));
    assign rot32 = (rs1[31:0] >> imm) | (rs1[31:0] << (6'd32 - {1'b0, imm}));

    assign rd = ({64{sel_rori}}  & rot64)
              | ({64{sel_roriw}} & {32'h0, rot32})
              | ({64{sel_pack}}  & {rs2[31:0], rs1[31:0]})
              | ({64{sel_packu}} & {rs2[63:32], rs1[63:32]});

endmodule

// File: rtl/rv64b_ise_arb.sv
// Round-robin two-port arbiter sharing one rv64b_ise datapath, with a registered response.
// Define RV64B_ISE_ARB_PIPE_EN to insert a stage-1 register before the datapath (2-cycle latency).
module rv64b_ise_arb
    import rv64b_ise_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             g_clk,
    input  logic             g_rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [1:0]       a_op,
    input  logic [63:0]      a_rs1,
    input  logic [63:0]      a_rs2,
    input  logic [4:0]       a_imm,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [1:0]       b_op,
    input  logic [63:0]      b_rs1,
    input  logic [63:0]      b_rs2,
    input  logic [4:0]       b_imm,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_rd,
    output logic             rsp_id,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    logic        rdy_en, ptr, grant_a, grant_b, can_acc, adv, acc_a, acc_b;
    ise_req_t    arb_req, dp_req;
    logic [63:0] dp_rd;

    // Holds ready low from reset until the first edge after reset is released.
    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) rdy_en <= 1'b0;
        else       rdy_en <= 1'b1;
    end

    assign grant_b = b_valid & (~a_valid | (ptr == ID_B));
    assign grant_a = a_valid & ~grant_b;
    assign a_ready = rdy_en & can_acc & grant_a;
    assign b_ready = rdy_en & can_acc & grant_b;
    assign acc_a   = a_valid & a_ready;
    assign acc_b   = b_valid & b_ready;
    assign adv     = ~rsp_valid | rsp_ready;

    always_comb begin
        arb_req     = '0;
        arb_req.vld = acc_a | acc_b;
        if (grant_b) begin
            arb_req.id  = ID_B;
            arb_req.sel = dec_op(b_op);
            arb_req.rs1 = b_rs1;
            arb_req.rs2 = b_rs2;
            arb_req.imm = b_imm;
        end else begin
            arb_req.id  = ID_A;
            arb_req.sel = dec_op(a_op);
            arb_req.rs1 = a_rs1;
            arb_req.rs2 = a_rs2;
            arb_req.imm = a_imm;
        end
    end

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst)                     ptr <= ID_A;
        else if (acc_a | acc_b)        ptr <= ~arb_req.id;
    end

`ifdef RV64B_ISE_ARB_PIPE_EN
    ise_req_t s1;

    assign can_acc = ~s1.vld | adv;
    assign dp_req  = s1;

    // Stage 1 refills (or empties) whenever it is empty or its contents move on.
    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst)        s1 <= '0;
        else if (can_acc) s1 <= arb_req;
    end
`else
    assign can_acc = adv;
    assign dp_req  = arb_req;
`endif

    rv64b_ise u_ise (
        .sel_rori  (dp_req.sel.rori),
        .sel_roriw (dp_req.sel.roriw),
        .sel_pack  (dp_req.sel.pack),
        .sel_packu (dp_req.sel.packu),
        .rs1       (dp_req.rs1),
        .rs2       (dp_req.rs2),
        .imm       (dp_req.imm),
        .rd        (dp_rd)
    );

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            rsp_valid <= 1'b0;
            rsp_rd    <= '0;
            rsp_id    <= ID_A;
        end else if (adv) begin
            rsp_valid <= dp_req.vld;
            if (dp_req.vld) begin
                rsp_rd <= dp_rd;
                rsp_id <= dp_req.id;
            end
        end
    end

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c, input logic inc,
                                                  input logic clr);
        if (clr)                 return '0;
        else if (inc && ~&c)     return c + 1'b1;
        else                     return c;
    endfunction

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            cnt_a <= cnt_next(cnt_a, acc_a, cnt_clr);
            cnt_b <= cnt_next(cnt_b, acc_b, cnt_clr);
        end
    end

endmodule

// File: tb/tb_rv64b_ise_arb.sv
// Bench for rv64b_ise_arb: directed table, streaming/backpressure/counter/reset sequences, random vs model.
module tb_rv64b_ise_arb;
    import rv64b_ise_pkg::*;

    localparam int CW = 4;
`ifdef RV64B_ISE_ARB_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [63:0] OPA = 64'h1111111122222222;
    localparam logic [63:0] OPB = 64'h3333333344444444;

    logic          g_clk, g_rst;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic [1:0]    a_op, b_op;
    logic [63:0]   a_rs1, a_rs2, b_rs1, b_rs2;
    logic [4:0]    a_imm, b_imm;
    logic          rsp_valid, rsp_ready, rsp_id, cnt_clr;
    logic [63:0]   rsp_rd;
    logic [CW-1:0] cnt_a, cnt_b;

    rv64b_ise_arb #(.CNT_W(CW)) dut (
        .g_clk(g_clk), .g_rst(g_rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_rs1(a_rs1), .a_rs2(a_rs2), .a_imm(a_imm),
        .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_rs1(b_rs1), .b_rs2(b_rs2), .b_imm(b_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_id(rsp_id),
        .cnt_clr(cnt_clr), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    int nvec = 0, nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: bitwise definition of each operation.
    function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [63:0] x,
                                           input logic [63:0] y, input logic [4:0] s);
        logic [63:0] r;
        r = '0;
        case (op)
            2'b00:   for (int i = 0; i < 64; i++) r[i] = x[(i + int'(s)) % 64];
            2'b01:   for (int i = 0; i < 32; i++) r[i] = x[(i + int'(s)) % 32];
            2'b10:   r = {y[31:0], x[31:0]};
            default: r = {y[63:32], x[63:32]};
        endcase
        return r;
    endfunction

    task automatic drive(input logic p, input logic [1:0] op, input logic [63:0] x,
                         input logic [63:0] y, input logic [4:0] s);
        if (p == ID_A) begin a_valid = 1; a_op = op; a_rs1 = x; a_rs2 = y; a_imm = s; end
        else           begin b_valid = 1; b_op = op; b_rs1 = x; b_rs2 = y; b_imm = s; end
    endtask

    typedef struct {
        logic        port;
        logic [1:0]  op;
        logic [63:0] rs1, rs2;
        logic [4:0]  imm;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] rd;
        logic        id;
    } rsp_t;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[9];
        rsp_t        q[$];
        rsp_t        r;
        int          na, nb, got, exp_id, n;
        logic [63:0] hold_rd;
        logic        hold_id, ptr, acc_a, acc_b, prev_stall;
        logic [63:0] prev_rd;
        logic        prev_id;
        int          ma, mb;

        tbl[0] = '{ID_A, 2'b00, 64'h0000000000000001, 64'h0, 5'd1,  64'h8000000000000000};
        tbl[1] = '{ID_B, 2'b01, 64'hFFFFFFFF00000001, 64'h0, 5'd4,  64'h0000000010000000};
        tbl[2] = '{ID_A, 2'b10, OPA, OPB, 5'd0,                      64'h4444444422222222};
        tbl[3] = '{ID_B, 2'b11, OPA, OPB, 5'd0,                      64'h3333333311111111};
        tbl[4] = '{ID_A, 2'b00, 64'h0123456789ABCDEF, 64'h0, 5'd0,  64'h0123456789ABCDEF};
        tbl[5] = '{ID_B, 2'b00, 64'h0123456789ABCDEF, 64'h0, 5'd4,  64'hF0123456789ABCDE};
        tbl[6] = '{ID_A, 2'b01, 64'hDEADBEEF80000001, 64'h0, 5'd31, 64'h0000000000000003};
        tbl[7] = '{ID_B, 2'b00, 64'h8000000000000001, 64'h0, 5'd31, 64'h0000000300000000};
        tbl[8] = '{ID_A, 2'b01, 64'hFFFF00001234ABCD, 64'h0, 5'd0,  64'h000000001234ABCD};

        // Reset with both ports already requesting pack / packu.
        g_rst = 1; cnt_clr = 0; rsp_ready = 1;
        a_valid = 0; b_valid = 0;
        drive(ID_A, 2'b10, OPA, OPB, 5'd0);
        drive(ID_B, 2'b11, OPA, OPB, 5'd0);
        #12;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rd", rsp_rd, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_ready", {a_ready, b_ready}, 0);
        chk("rst_cnt", {cnt_a, cnt_b}, 0);
        g_rst = 0;
        #1;
        chk("rel_ready_low", {a_ready, b_ready}, 0);

        // Continuous contention: A,B,A,B one per cycle, then backpressure, then release.
        exp_id = 0; got = 0;
        for (int c = 0; c < 30 && got < 6; c++) begin
            @(negedge g_clk);
            if (rsp_valid) begin
                chk("stream_id", rsp_id, exp_id);
                chk("stream_rd", rsp_rd, exp_id ? 64'h3333333311111111 : 64'h4444444422222222);
                exp_id ^= 1; got++;
            end else if (got > 0) chk("stream_gap", rsp_valid, 1);
        end
        chk("stream_count", got, 6);
        @(posedge g_clk); #1 rsp_ready = 0;
        hold_rd = '0; hold_id = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge g_clk);
            if (k == 0) begin
                chk("bp_valid", rsp_valid, 1);
                chk("bp_id0", rsp_id, exp_id);
                hold_rd = rsp_rd; hold_id = rsp_id;
            end else begin
                chk("bp_rd_hold", rsp_rd, hold_rd);
                chk("bp_id_hold", rsp_id, hold_id);
                chk("bp_ready_low", {a_ready, b_ready}, 0);
            end
        end
        @(posedge g_clk); #1 rsp_ready = 1;
        got = 0;
        for (int c = 0; c < 30 && got < 6; c++) begin
            @(negedge g_clk);
            if (rsp_valid) begin
                chk("bp_rel_id", rsp_id, exp_id);
                exp_id ^= 1; got++;
            end else chk("bp_rel_gap", rsp_valid, 1);
        end
        chk("bp_rel_count", got, 6);
        @(posedge g_clk); #1 a_valid = 0; b_valid = 0;
        repeat (4) @(posedge g_clk);

        // Directed table: one request at a time, checked at the nominal latency.
        #1 cnt_clr = 1;
        @(posedge g_clk); #1 cnt_clr = 0;
        na = 0; nb = 0;
        foreach (tbl[i]) begin
            @(posedge g_clk); #1;
            drive(tbl[i].port, tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
            @(negedge g_clk);
            chk($sformatf("tbl%0d_ready", i), tbl[i].port ? b_ready : a_ready, 1);
            @(posedge g_clk); #1 a_valid = 0; b_valid = 0;
            repeat (LAT - 1) @(posedge g_clk);
            @(negedge g_clk);
            chk($sformatf("tbl%0d_valid", i), rsp_valid, 1);
            chk($sformatf("tbl%0d_rd", i), rsp_rd, tbl[i].exp);
            chk($sformatf("tbl%0d_id", i), rsp_id, tbl[i].port);
            if (tbl[i].port) nb++; else na++;
        end
        @(negedge g_clk);
        chk("tbl_cnt_a", cnt_a, na);
        chk("tbl_cnt_b", cnt_b, nb);

        // Saturation: 2^CW + 3 accepts on A.
        @(posedge g_clk); #1 cnt_clr = 1;
        @(posedge g_clk); #1 cnt_clr = 0;
        @(negedge g_clk);
        chk("clr_cnt", {cnt_a, cnt_b}, 0);
        @(posedge g_clk); #1 drive(ID_A, 2'b00, 64'h5, 64'h0, 5'd3);
        n = 0;
        for (int c = 0; c < 100 && n < (1 << CW) + 3; c++) begin
            @(negedge g_clk);
            if (a_ready) n++;
            if (n < (1 << CW) + 3) @(posedge g_clk);
        end
        chk("sat_accepts", n, (1 << CW) + 3);
        @(posedge g_clk); #1 a_valid = 0;
        @(negedge g_clk);
        chk("sat_cnt_a", cnt_a, {CW{1'b1}});
        chk("sat_cnt_b", cnt_b, 0);
        @(posedge g_clk); #1 drive(ID_A, 2'b00, 64'h5, 64'h0, 5'd3); cnt_clr = 1;
        @(negedge g_clk);
        chk("clr_acc_ready", a_ready, 1);
        @(posedge g_clk); #1 a_valid = 0; cnt_clr = 0;
        @(negedge g_clk);
        chk("clr_acc_cnt", cnt_a, 0);
        repeat (3) @(posedge g_clk);

        // Reset with one operation in flight.
        #1 drive(ID_B, 2'b10, OPA, OPB, 5'd0);
        @(negedge g_clk);
        chk("mid_ready", b_ready, 1);
        @(posedge g_clk); #1 b_valid = 0; g_rst = 1;
        #1;
        chk("mid_rsp_valid", rsp_valid, 0);
        @(negedge g_clk); g_rst = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge g_clk);
            chk("mid_no_stale", rsp_valid, 0);
        end
        chk("mid_cnt", {cnt_a, cnt_b}, 0);
        @(posedge g_clk); #1;
        drive(ID_A, 2'b10, OPA, OPB, 5'd0);
        drive(ID_B, 2'b11, OPA, OPB, 5'd0);
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge g_clk);
            if (rsp_valid) begin chk("mid_ptr_a", rsp_id, ID_A); got++; end
        end
        chk("mid_resp_seen", got, 1);
        @(posedge g_clk); #1 a_valid = 0; b_valid = 0;
        repeat (4) @(posedge g_clk);

        // Randomised traffic against the queue model.
        #1 g_rst = 1;
        @(negedge g_clk); g_rst = 0;
        repeat (2) @(posedge g_clk);
        ptr = ID_A; ma = 0; mb = 0; acc_a = 0; acc_b = 0;
        prev_stall = 0; prev_rd = '0; prev_id = 0;
        for (int c = 0; c < 600; c++) begin
            @(posedge g_clk); #1;
            if (acc_a || !a_valid) begin
                a_valid = 0;
                if ($urandom_range(0, 3) != 0)
                    drive(ID_A, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
            end
            if (acc_b || !b_valid) begin
                b_valid = 0;
                if ($urandom_range(0, 3) != 0)
                    drive(ID_B, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 31) == 0);
            @(negedge g_clk);
            chk("rnd_cnt_a", cnt_a, ma);
            chk("rnd_cnt_b", cnt_b, mb);
            acc_a = a_valid & a_ready;
            acc_b = b_valid & b_ready;
            chk("rnd_ready_excl", a_ready & b_ready, 0);
            chk("rnd_ready_needs_valid", (a_ready & ~a_valid) | (b_ready & ~b_valid), 0);
            if (a_valid && b_valid && (a_ready || b_ready))
                chk("rnd_rr_grant", b_ready, ptr);
            if ((a_valid || b_valid) && (!rsp_valid || rsp_ready))
                chk("rnd_no_accept", a_ready | b_ready, 1);
            if (prev_stall) begin
                chk("rnd_hold_rd", rsp_rd, prev_rd);
                chk("rnd_hold_id", rsp_id, prev_id);
            end
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) chk("rnd_spurious_rsp", rsp_valid, 0);
                else begin
                    r = q.pop_front();
                    chk("rnd_rd", rsp_rd, r.rd);
                    chk("rnd_id", rsp_id, r.id);
                end
            end
            prev_stall = rsp_valid & ~rsp_ready;
            prev_rd = rsp_rd; prev_id = rsp_id;
            if (acc_a) begin q.push_back('{ref_op(a_op, a_rs1, a_rs2, a_imm), ID_A}); ptr = ID_B; end
            if (acc_b) begin q.push_back('{ref_op(b_op, b_rs1, b_rs2, b_imm), ID_B}); ptr = ID_A; end
            if (cnt_clr) begin ma = 0; mb = 0; end
            else begin
                if (acc_a && ma < (1 << CW) - 1) ma++;
                if (acc_b && mb < (1 << CW) - 1) mb++;
            end
        end
        @(posedge g_clk); #1 a_valid = 0; b_valid = 0; rsp_ready = 1; cnt_clr = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge g_clk);
            if (rsp_valid) begin
                if (q.size() == 0) chk("drain_spurious_rsp", rsp_valid, 0);
                else begin
                    r = q.pop_front();
                    chk("drain_rd", rsp_rd, r.rd);
                    chk("drain_id", rsp_id, r.id);
                end
            end
        end
        chk("drain_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/rv64b_ise_arb.md
# rv64b_ise_arb

Two-port arbiter and sequencer that shares one rotate/pack ISE datapath (rori, roriw, pack, packu) between two requesters, such as a scalar issue port and a Sparkle permutation sequencer. It does the following:
- Accepts operations over valid/ready handshakes.
- Grants the datapath round-robin.
- Registers the result into a single response channel tagged with the requester ID.
- Keeps saturating per-port accept counters for performance monitoring.

## Interface
Parameters:
- CNT_W, 16, width of each per-port accept counter

Ports:
- g_clk  in  1  clock; all state updates on the rising edge
- g_rst  in  1  asynchronous, active-high reset
- a_valid  in  1  port A request valid
- a_ready  out  1  port A request accepted this cycle
- a_op  in  2  port A opcode: 00 rori, 01 roriw, 10 pack, 11 packu
- a_rs1, a_rs2  in  64  port A operands
- a_imm  in  5  port A rotate amount
- b_valid, b_ready, b_op, b_rs1, b_rs2, b_imm: the same set as port A, for port B
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_rd  out  64  result
- rsp_id  out  1  requester of the result: 0 = A, 1 = B
- cnt_clr  in  1  synchronous clear of both counters
- cnt_a, cnt_b  out  CNT_W  accepted-request counts

## Operation
Handshake rules:
- A request transfers when x_valid and x_ready are both high.
- A requester holds valid and payload stable until the request is accepted.
- x_ready is asserted only to the granted port, and only when the block can accept.

Arbitration:
- If exactly one port is valid, that port is granted.
- If both ports are valid, the port selected by the priority pointer is granted.
- After an accepted grant, the pointer moves to the other port.
- The pointer is unchanged when nothing is accepted.

Datapath:
- The 2-bit opcode is decoded to one-hot selects driving the shared datapath.
- rori rotates the 64-bit rs1 right by imm (0..31).
- roriw rotates rs1[31:0] right by imm; the upper 32 bits of the result are zero.
- pack returns {rs2[31:0], rs1[31:0]}.
- packu returns {rs2[63:32], rs1[63:32]}.

Output register:
- The output register holds one result.
- The block can accept when !rsp_valid | rsp_ready. In pipelined mode it can accept when stage 1 can advance (see Configuration).
- Accept and drain in the same cycle sustain one operation per cycle.

Counters:
- cnt_a and cnt_b each increment by 1 per accepted request on their port.
- Each counter saturates at all ones.
- cnt_clr takes priority: a clear and an accept in the same cycle leave the counter at 0.

## Timing
Reset values:
- rsp_valid 0, rsp_rd 0, rsp_id 0
- a_ready 0, b_ready 0
- cnt_a 0, cnt_b 0
- priority pointer = A

Latency and throughput:
- Base latency: a request accepted in cycle N gives rsp_valid in cycle N+1.
- Throughput is 1 operation per cycle while rsp_ready is high.

Backpressure:
- While rsp_valid is high and rsp_ready is low, rsp_rd and rsp_id hold and both ready outputs are low.

Reset mid-operation:
- All in-flight operations are dropped and no response is produced.
- Ready outputs stay low until the first clock edge after g_rst deasserts.

Combinational paths:
- x_ready depends combinationally on a_valid, b_valid, rsp_ready and internal state.
- x_ready never depends on operand values.

## Configuration
- RV64B_ISE_ARB_PIPE_EN defined:
  - A stage-1 register (valid, one-hot op, rs1, rs2, imm, id) is inserted between the arbiter and the datapath.
  - Latency is 2 cycles. Throughput remains 1 per cycle.
  - Stage 1 advances when !rsp_valid | rsp_ready.
  - The block accepts when !s1_valid | stage-1 advance.
  - The stage-1 valid bit resets to 0.
- RV64B_ISE_ARB_PIPE_EN undefined: the arbiter feeds the datapath directly and latency is 1 cycle.
- In both modes the counters, arbitration and result values are identical.

## Structure
- Package rv64b_ise_pkg holds:
  - opcode localparams: OP_RORI = 2'b00, OP_RORIW = 2'b01, OP_PACK = 2'b10, OP_PACKU = 2'b11
  - requester IDs: ID_A = 1'b0, ID_B = 1'b1
- One sub-module: the existing combinational rv64b_ise datapath, instantiated unmodified with one-hot select inputs.
- Arbitration, pipeline registers, output register and counters live in rv64b_ise_arb.

## Test plan
- rori: A-only, op 00, rs1 0x0000000000000001, imm 1 -> rsp_rd 0x8000000000000000, rsp_id 0, in cycle N+1 (N+2 with PIPE), cnt_a = 1.
- roriw: B-only, op 01, rs1 0xFFFFFFFF00000001, imm 4 -> rsp_rd 0x0000000010000000, rsp_id 1.
- Both ports valid continuously from reset:
  - A: pack, rs1 0x1111111122222222, rs2 0x3333333344444444 -> 0x4444444422222222.
  - B: packu, same operands -> 0x3333333311111111.
  - Responses alternate A, B, A, B; one per cycle with rsp_ready = 1.
- Backpressure: hold rsp_ready = 0 for 5 cycles with a result pending -> rsp_rd and rsp_id stable, a_ready = b_ready = 0. Release -> no result lost or duplicated.
- Counters:
  - Drive 2^CNT_W + 3 accepts on port A (CNT_W = 4 override) -> cnt_a = 0xF.
  - Assert cnt_clr during an accept -> cnt_a = 0 the next cycle.
- Reset mid-operation: assert g_rst with one operation in flight -> rsp_valid = 0 immediately. After release, no stale response appears, the priority pointer is A, and the counters are 0.
